// File: rtl/carry_pred_ctrl_if.sv
// Operand/result handshake bundle for carry_pred_ctrl.
// master drives operands and result-ready; slave is the controller.
interface carry_pred_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
);
  localparam int NSEG = WIDTH / SEG;
  localparam int IW   = $clog2(NSEG);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH:0]   sum_o;
  logic             err_o;
  logic [IW-1:0]    iter_o;
  logic [NSEG-1:0]  sel_o;
  logic [NSEG-1:0]  ci_prdt_o;

  modport master (
    output valid_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, sum_o, err_o, iter_o, sel_o, ci_prdt_o
  );

  modport slave (
    input  valid_i, a_i, b_i, ready_i,
    output ready_o, valid_o, sum_o, err_o, iter_o, sel_o, ci_prdt_o
  );
endinterface

// File: rtl/carry_pred_ctrl.sv
// Speculative segmented-adder controller: predicts segment carries, detects mispredictions.
// Define CSEL_RECOVERY_EN to iterate with exact carries until the sum is exact.
module carry_pred_ctrl #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  carry_pred_ctrl_if.slave  bus
);
  localparam int NSEG = WIDTH / SEG;
  localparam int IW   = $clog2(NSEG);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [NSEG-1:0]  sel_r;
  logic [NSEG-1:0]  ci_prdt;
  logic [NSEG-1:0]  m;
  logic [WIDTH:0]   sum_r;
  logic [WIDTH:0]   sum_c;
  logic             err_r;
  logic             carry;
  logic             cin;
  logic [SEG:0]     seg_sum;
`ifdef CSEL_RECOVERY_EN
  logic [IW-1:0]    iter_cnt;
  logic [IW-1:0]    iter_r;
`endif

  // Predicted carry into segment k is the generate of the previous segment's MSB.
  always_comb begin
    ci_prdt = '0;
    for (int k = 1; k < NSEG; k++) begin
      ci_prdt[k] = a_r[k*SEG-1] & b_r[k*SEG-1];
    end
  end

  // Ripple through segments; carry holds the previous segment's local carry-out.
  always_comb begin
    sum_c   = '0;
    m       = '0;
    carry   = 1'b0;
    cin     = 1'b0;
    seg_sum = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (k == 0) begin
        cin = 1'b0;
      end else begin
        cin  = sel_r[k] ? ci_prdt[k] : carry;
        m[k] = sel_r[k] & (ci_prdt[k] != carry);
      end
      seg_sum = {1'b0, a_r[k*SEG +: SEG]} + {1'b0, b_r[k*SEG +: SEG]} + {{SEG{1'b0}}, cin};
      sum_c[k*SEG +: SEG] = seg_sum[SEG-1:0];
      carry = seg_sum[SEG];
    end
    sum_c[WIDTH] = carry;
  end

  // Control FSM; each recovery round pins every mismatched segment to its actual carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      sel_r <= '0;
      sum_r <= '0;
      err_r <= 1'b0;
`ifdef CSEL_RECOVERY_EN
      iter_cnt <= '0;
      iter_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            a_r   <= bus.a_i;
            b_r   <= bus.b_i;
            sel_r <= {{(NSEG-1){1'b1}}, 1'b0};
`ifdef CSEL_RECOVERY_EN
            iter_cnt <= '0;
`endif
            state <= EVAL;
          end
        end
        EVAL: begin
`ifdef CSEL_RECOVERY_EN
          if (iter_cnt == '0) err_r <= |m;
          if (m == '0) begin
            sum_r  <= sum_c;
            iter_r <= iter_cnt;
            state  <= DONE;
          end else begin
            sel_r    <= sel_r & ~m;
            iter_cnt <= iter_cnt + 1'b1;
          end
`else
          err_r <= |m;
          sum_r <= sum_c;
          state <= DONE;
`endif
        end
        DONE: begin
          if (bus.ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o   = (state == IDLE);
  assign bus.valid_o   = (state == DONE);
  assign bus.sum_o     = sum_r;
  assign bus.err_o     = err_r;
  assign bus.sel_o     = sel_r;
  assign bus.ci_prdt_o = ci_prdt;
`ifdef CSEL_RECOVERY_EN
  assign bus.iter_o    = iter_r;
`else
  assign bus.iter_o    = '0;
`endif
endmodule
